// File: rtl/rtc_pkg.sv
// Shared RTC constants: flag bit positions and flag-vector sizing.
package rtc_pkg;

    localparam int unsigned FLG_TICK  = 0;
    localparam int unsigned FLG_OVF   = 1;
    localparam int unsigned FLG_ALRM0 = 2;

    // Flag vector holds tick, overflow, then one bit per alarm channel.
    function automatic int unsigned flg_width(input int unsigned alrm_num);
        return alrm_num + FLG_ALRM0;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// RTC prescaler: down-counter that emits a one-cycle tick every pscr+1 enabled cycles.
module rtc_prescaler #(
    parameter int unsigned PSCR_WIDTH = 20
) (
    input  logic                  rtc_clk_i,
    input  logic                  rtc_rst_n_i,
    input  logic                  en_i,
    input  logic                  pscr_we_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    output logic [PSCR_WIDTH-1:0] div_o,
    output logic                  tick_c
);

    logic [PSCR_WIDTH-1:0] pscr_q;
    logic [PSCR_WIDTH-1:0] div_q;

    // A prescaler write restarts the count and suppresses that cycle's tick.
    always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
        if (!rtc_rst_n_i) begin
            pscr_q <= '0;
            div_q  <= '0;
        end else if (pscr_we_i) begin
            pscr_q <= pscr_i;
            div_q  <= pscr_i;
        end else if (en_i) begin
            div_q <= (div_q == '0) ? pscr_q : div_q - PSCR_WIDTH'(1);
        end
    end

    assign tick_c = en_i && !pscr_we_i && (div_q == '0);
    assign div_o  = div_q;

endmodule

// File: rtl/rtc_alarm_core.sv
// RTC calendar counter with per-channel alarm compare, sticky event flags and a registered IRQ.
module rtc_alarm_core
    import rtc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned PSCR_WIDTH = 20,
    parameter int unsigned ALRM_NUM   = 4
) (
    input  logic                            rtc_clk_i,
    input  logic                            rtc_rst_n_i,
    input  logic                            en_i,
    input  logic                            pscr_we_i,
    input  logic [PSCR_WIDTH-1:0]           pscr_i,
    input  logic                            cnt_we_i,
    input  logic [CNT_WIDTH-1:0]            cnt_i,
    input  logic [ALRM_NUM-1:0]             alrm_we_i,
    input  logic [CNT_WIDTH-1:0]            alrm_i,
    input  logic [flg_width(ALRM_NUM)-1:0]  ie_i,
    input  logic [flg_width(ALRM_NUM)-1:0]  clr_i,
    output logic [PSCR_WIDTH-1:0]           div_o,
    output logic [CNT_WIDTH-1:0]            cnt_o,
    output logic [flg_width(ALRM_NUM)-1:0]  flag_o,
    output logic                            irq_o
);

    localparam int unsigned FLG_W = flg_width(ALRM_NUM);

    logic                 tick_c;
    logic                 evt_c;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_inc_c;
    logic [ALRM_NUM-1:0]  alrm_hit_c;
    logic [FLG_W-1:0]     flag_q;
    logic [FLG_W-1:0]     flag_set_c;
    logic                 irq_q;

    rtc_prescaler #(
        .PSCR_WIDTH (PSCR_WIDTH)
    ) u_prescaler (
        .rtc_clk_i   (rtc_clk_i),
        .rtc_rst_n_i (rtc_rst_n_i),
        .en_i        (en_i),
        .pscr_we_i   (pscr_we_i),
        .pscr_i      (pscr_i),
        .div_o       (div_o),
        .tick_c      (tick_c)
    );

    // A counter load wins over a coincident tick and masks all of its events.
    assign evt_c     = tick_c && !cnt_we_i;
    assign cnt_inc_c = cnt_q + CNT_WIDTH'(1);

    for (genvar k = 0; k < ALRM_NUM; k++) begin : g_alrm
        logic [CNT_WIDTH-1:0] alrm_q;

        always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
            if (!rtc_rst_n_i) begin
                alrm_q <= '0;
            end else if (alrm_we_i[k]) begin
                alrm_q <= alrm_i;
            end
        end

        assign alrm_hit_c[k] = (alrm_q == cnt_inc_c);
    end

    always_comb begin
        flag_set_c = '0;
        if (evt_c) begin
            flag_set_c = {alrm_hit_c, &cnt_q, 1'b1};
        end
    end

    always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
        if (!rtc_rst_n_i) begin
            cnt_q <= '0;
        end else if (cnt_we_i) begin
            cnt_q <= cnt_i;
        end else if (tick_c) begin
            cnt_q <= cnt_inc_c;
        end
    end

    // Set beats clear; IRQ follows the visible flags by one cycle.
    always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
        if (!rtc_rst_n_i) begin
            flag_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            flag_q <= (flag_q & ~clr_i) | flag_set_c;
            irq_q  <= |(flag_q & ie_i);
        end
    end

    assign cnt_o  = cnt_q;
    assign flag_o = flag_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_rtc_alarm_core.sv
// Directed self-checking bench for rtc_alarm_core.
module tb_rtc_alarm_core;

    localparam int unsigned CW = 32;
    localparam int unsigned PW = 20;
    localparam int unsigned AN = 4;
    localparam int unsigned FW = AN + 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          pscr_we;
    logic [PW-1:0] pscr;
    logic          cnt_we;
    logic [CW-1:0] cnt_in;
    logic [AN-1:0] alrm_we;
    logic [CW-1:0] alrm;
    logic [FW-1:0] ie;
    logic [FW-1:0] clr;
    logic [PW-1:0] div_o;
    logic [CW-1:0] cnt_o;
    logic [FW-1:0] flag_o;
    logic          irq_o;

    int checks = 0;
    int errors = 0;

    rtc_alarm_core #(
        .CNT_WIDTH  (CW),
        .PSCR_WIDTH (PW),
        .ALRM_NUM   (AN)
    ) dut (
        .rtc_clk_i   (clk),
        .rtc_rst_n_i (rst_n),
        .en_i        (en),
        .pscr_we_i   (pscr_we),
        .pscr_i      (pscr),
        .cnt_we_i    (cnt_we),
        .cnt_i       (cnt_in),
        .alrm_we_i   (alrm_we),
        .alrm_i      (alrm),
        .ie_i        (ie),
        .clr_i       (clr),
        .div_o       (div_o),
        .cnt_o       (cnt_o),
        .flag_o      (flag_o),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        en = 1'b0; pscr_we = 1'b0; pscr = '0; cnt_we = 1'b0; cnt_in = '0;
        alrm_we = '0; alrm = '0; ie = '0; clr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (cnt_o !== '0)  begin errors++; $display("FAIL reset_cnt got %0h exp 0", cnt_o); end
        checks++; if (div_o !== '0)  begin errors++; $display("FAIL reset_div got %0h exp 0", div_o); end
        checks++; if (flag_o !== '0) begin errors++; $display("FAIL reset_flag got %0h exp 0", flag_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b exp 0", irq_o); end
        // pscr=0, en=1 across release: first edge ticks
        @(negedge clk);
        en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cnt_o !== CW'(1)) begin errors++; $display("FAIL first_tick_cnt got %0h exp 1", cnt_o); end
        checks++; if (flag_o[0] !== 1'b1) begin errors++; $display("FAIL first_tick_flag got %0b exp 1", flag_o[0]); end
    endtask

    task automatic test_prescaler();
        logic [PW-1:0] div_hold;
        do_reset();
        pscr_we = 1'b1; pscr = PW'(3); en = 1'b1;
        @(negedge clk);
        pscr_we = 1'b0;
        checks++; if (div_o !== PW'(3)) begin errors++; $display("FAIL pscr_load_div got %0h exp 3", div_o); end
        checks++; if (cnt_o !== '0) begin errors++; $display("FAIL pscr_load_cnt got %0h exp 0", cnt_o); end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (cnt_o !== CW'(i / 4)) begin
                errors++; $display("FAIL pscr_cnt[%0d] got %0h exp %0h", i, cnt_o, i / 4);
            end
            checks++;
            if (div_o !== PW'(3 - (i % 4))) begin
                errors++; $display("FAIL pscr_div[%0d] got %0h exp %0h", i, div_o, 3 - (i % 4));
            end
        end
        en = 1'b0;
        div_hold = div_o;
        repeat (5) @(negedge clk);
        checks++; if (cnt_o !== CW'(2)) begin errors++; $display("FAIL hold_cnt got %0h exp 2", cnt_o); end
        checks++; if (div_o !== PW'(3)) begin errors++; $display("FAIL hold_div got %0h exp 3 (was %0h)", div_o, div_hold); end
    endtask

    task automatic test_overflow();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            ie = (pass == 1) ? FW'(2) : FW'(0);
            cnt_we = 1'b1; cnt_in = 32'hFFFF_FFFE;
            @(negedge clk);
            cnt_we = 1'b0;
            checks++; if (cnt_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL ovf_load got %0h exp fffffffe", cnt_o); end
            en = 1'b1;
            @(negedge clk);
            checks++; if (cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_pre got %0h exp ffffffff", cnt_o); end
            checks++; if (flag_o[1:0] !== 2'b01) begin errors++; $display("FAIL ovf_pre_flags got %0b exp 01", flag_o[1:0]); end
            @(negedge clk);
            en = 1'b0;
            checks++; if (cnt_o !== '0) begin errors++; $display("FAIL ovf_wrap got %0h exp 0", cnt_o); end
            checks++; if (flag_o[1] !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", flag_o[1]); end
            checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL ovf_irq_early[%0d] got %0b exp 0", pass, irq_o); end
            @(negedge clk);
            checks++;
            if (irq_o !== 1'(pass)) begin
                errors++; $display("FAIL ovf_irq[%0d] got %0b exp %0b", pass, irq_o, pass);
            end
        end
    endtask

    task automatic test_alarm();
        do_reset();
        alrm_we = 4'b0101; alrm = CW'(10);
        @(negedge clk);
        alrm_we = 4'b0010; alrm = CW'(11);
        @(negedge clk);
        alrm_we = '0;
        en = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            checks++;
            if (flag_o[5:2] !== {1'b0, 1'(n >= 10), 1'(n >= 11), 1'(n >= 10)} || cnt_o !== CW'(n)) begin
                errors++; $display("FAIL alarm_step[%0d] got cnt %0h flags %0b", n, cnt_o, flag_o);
            end
        end
        // alarm 3 written in the same cycle the count reaches 12: old value compared
        alrm_we = 4'b1000; alrm = CW'(12);
        @(negedge clk);
        alrm_we = '0; en = 1'b0;
        checks++; if (flag_o[5] !== 1'b0 || cnt_o !== CW'(12)) begin errors++; $display("FAIL alarm_old_value got cnt %0h flag5 %0b exp 12/0", cnt_o, flag_o[5]); end
        cnt_we = 1'b1; cnt_in = CW'(11);
        @(negedge clk);
        cnt_we = 1'b0; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks++; if (flag_o[5] !== 1'b1) begin errors++; $display("FAIL alarm_new_value got %0b exp 1", flag_o[5]); end
    endtask

    task automatic test_cnt_load();
        do_reset();
        en = 1'b1; cnt_we = 1'b1; cnt_in = CW'(8'h55);
        @(negedge clk);
        cnt_we = 1'b0;
        checks++; if (cnt_o !== CW'(8'h55)) begin errors++; $display("FAIL load_prio_cnt got %0h exp 55", cnt_o); end
        checks++; if (flag_o[0] !== 1'b0) begin errors++; $display("FAIL load_prio_flag got %0b exp 0", flag_o[0]); end
        @(negedge clk);
        checks++; if (cnt_o !== CW'(8'h56) || flag_o[0] !== 1'b1) begin errors++; $display("FAIL load_then_tick got %0h/%0b exp 56/1", cnt_o, flag_o[0]); end
    endtask

    task automatic test_clear();
        // continues from test_cnt_load: pscr=0, en=1, flag[0]=1
        ie = FW'(1);
        clr = FW'(1);
        @(negedge clk);
        checks++; if (flag_o[0] !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %0b exp 1", flag_o[0]); end
        en = 1'b0;
        @(negedge clk);
        clr = '0;
        checks++; if (flag_o[0] !== 1'b0) begin errors++; $display("FAIL clr_alone got %0b exp 0", flag_o[0]); end
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL clr_irq_lag got %0b exp 1", irq_o); end
        @(negedge clk);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL clr_irq_drop got %0b exp 0", irq_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        @(negedge clk);
        ie = '1; pscr_we = 1'b1; pscr = PW'(3); cnt_we = 1'b1; cnt_in = CW'(7);
        @(negedge clk);
        pscr_we = 1'b0; cnt_we = 1'b0;
        @(negedge clk);
        checks++; if (cnt_o !== CW'(7) || div_o !== PW'(2)) begin errors++; $display("FAIL mid_pre got cnt %0h div %0h exp 7/2", cnt_o, div_o); end
        checks++; if (flag_o[0] !== 1'b1 || irq_o !== 1'b1) begin errors++; $display("FAIL mid_pre_flags got %0b/%0b exp 1/1", flag_o[0], irq_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cnt_o !== '0)  begin errors++; $display("FAIL async_cnt got %0h exp 0", cnt_o); end
        checks++; if (div_o !== '0)  begin errors++; $display("FAIL async_div got %0h exp 0", div_o); end
        checks++; if (flag_o !== '0) begin errors++; $display("FAIL async_flag got %0h exp 0", flag_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL async_irq got %0b exp 0", irq_o); end
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cnt_o !== '0) begin errors++; $display("FAIL post_reset_hold got %0h exp 0", cnt_o); end
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_overflow();
        test_alarm();
        test_cnt_load();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
